acc_writeback: RTL and testbench

ACC_WRITEBACK -- requirements
Module: acc_writeback

---
 rtl/acc_writeback.sv | 153 +++++++++++++++
 tb/tb_acc_writeback.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_writeback.sv
// Accumulator writeback / branch-resolve stage.
//
// Takes one ALU result per handshake. The entry is either written into the
// accumulator, used to resolve a branch, or dropped as a no-op. The outcome is
// then held for the PC/control unit until that unit consumes it. Each
// consumed entry increments retire_cnt.
//
// Optional feature: define ACC_WB_FLAGS_EN to drive flag_z/flag_n from the
// accumulator. When it is undefined, both flags are tied low and the ports
// remain present.
//
// Ports:
//   CLK          in   rising-edge clock
//   Reset_n      in   asynchronous active-low reset
//   in_valid     in   upstream ALU result valid
//   in_ready     out  stage can accept this cycle
//   alu_result   in   [15:0] signed ALU result
//   ble          in   ALU B<=A flag
//   branch_eq    in   ALU A==B flag
//   wb_sel       in   [1:0] 00 none, 01 acc write, 10 branch eval, 11 none
//   br_cond      in   [1:0] 00 beq, 01 bne, 10 ble, 11 bgt
//   out_ready    in   downstream consumes held entry
//   out_valid    out  held entry present
//   acc          out  [15:0] accumulator
//   branch_taken out  branch decision of held entry
//   retire_cnt   out  [15:0] completed-handshake counter (wraps)
//   flag_z       out  accumulator zero
//   flag_n       out  accumulator negative
module acc_writeback #(
  parameter logic [15:0] RESET_ACC = 16'h0000
) (
  input  logic        CLK,
  input  logic        Reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] alu_result,
  input  logic        ble,
  input  logic        branch_eq,
  input  logic [1:0]  wb_sel,
  input  logic [1:0]  br_cond,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [15:0] acc,
  output logic        branch_taken,
  output logic [15:0] retire_cnt,
  output logic        flag_z,
  output logic        flag_n
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  localparam logic [1:0] WbAcc    = 2'b01;
  localparam logic [1:0] WbBranch = 2'b10;

  state_e      state_q, state_d;
  logic [15:0] acc_q, acc_d;
  logic        taken_q, taken_d;
  logic [15:0] retire_q, retire_d;
  logic [1:0]  wb_sel_q, wb_sel_d;
  logic [1:0]  br_cond_q, br_cond_d;
  logic        ble_q, ble_d;
  logic        beq_q, beq_d;

  logic accept;
  logic retire;
  logic cond_true;

  always_comb begin
    unique case (br_cond)
      2'b00:   cond_true = branch_eq;
      2'b01:   cond_true = ~branch_eq;
      2'b10:   cond_true = ble;
      default: cond_true = ~ble;
    endcase
  end

  // A held entry may retire and be replaced in the same cycle, so no bubble
  // is needed between back-to-back transfers.
  assign in_ready = (state_q == StIdle) || out_ready;
  assign accept   = in_valid && in_ready;
  assign retire   = (state_q == StHold) && out_ready;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    taken_d   = taken_q;
    retire_d  = retire_q;
    wb_sel_d  = wb_sel_q;
    br_cond_d = br_cond_q;
    ble_d     = ble_q;
    beq_d     = beq_q;

    if (retire) begin
      retire_d = retire_q + 16'd1;
    end

    if (accept) begin
      state_d   = StHold;
      wb_sel_d  = wb_sel;
      br_cond_d = br_cond;
      ble_d     = ble;
      beq_d     = branch_eq;
      taken_d   = (wb_sel == WbBranch) && cond_true;
      if (wb_sel == WbAcc) begin
        acc_d = alu_result;
      end
    end else if (retire) begin
      state_d = StIdle;
      taken_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q   <= StIdle;
      acc_q     <= RESET_ACC;
      taken_q   <= 1'b0;
      retire_q  <= 16'h0000;
      wb_sel_q  <= 2'b00;
      br_cond_q <= 2'b00;
      ble_q     <= 1'b0;
      beq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      taken_q   <= taken_d;
      retire_q  <= retire_d;
      wb_sel_q  <= wb_sel_d;
      br_cond_q <= br_cond_d;
      ble_q     <= ble_d;
      beq_q     <= beq_d;
    end
  end

  // The captured select/condition/flags are kept with the entry for
  // downstream observability; only branch_taken is exported today.
  logic unused_capture;
  assign unused_capture = ^{wb_sel_q, br_cond_q, ble_q, beq_q};

  assign out_valid    = (state_q == StHold);
  assign acc          = acc_q;
  assign branch_taken = taken_q;
  assign retire_cnt   = retire_q;

`ifdef ACC_WB_FLAGS_EN
  assign flag_z = (acc_q == 16'h0000);
  assign flag_n = acc_q[15];
`else
  assign flag_z = 1'b0;
  assign flag_n = 1'b0;
`endif

endmodule

// File: tb/tb_acc_writeback.sv
// Directed testbench for acc_writeback. It applies stimulus and checks the
// outputs on a fixed cycle schedule. The expected values are hand-computed.
module tb_acc_writeback;

  logic        CLK;
  logic        Reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] alu_result;
  logic        ble;
  logic        branch_eq;
  logic [1:0]  wb_sel;
  logic [1:0]  br_cond;
  logic        out_ready;
  logic        out_valid;
  logic [15:0] acc;
  logic        branch_taken;
  logic [15:0] retire_cnt;
  logic        flag_z;
  logic        flag_n;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  acc_writeback #(
    .RESET_ACC (16'h0000)
  ) dut (
    .CLK          (CLK),
    .Reset_n      (Reset_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .alu_result   (alu_result),
    .ble          (ble),
    .branch_eq    (branch_eq),
    .wb_sel       (wb_sel),
    .br_cond      (br_cond),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .acc          (acc),
    .branch_taken (branch_taken),
    .retire_cnt   (retire_cnt),
    .flag_z       (flag_z),
    .flag_n       (flag_n)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) begin
      passed++;
    end else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_flags(input string tag, input logic [15:0] acc_exp);
    logic z_exp;
    logic n_exp;
`ifdef ACC_WB_FLAGS_EN
    z_exp = (acc_exp == 16'h0000);
    n_exp = acc_exp[15];
`else
    z_exp = 1'b0;
    n_exp = 1'b0;
`endif
    check({tag, "_z"}, {15'd0, flag_z}, {15'd0, z_exp});
    check({tag, "_n"}, {15'd0, flag_n}, {15'd0, n_exp});
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    Reset_n   = 1'b0;
    #3;
    Reset_n   = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [15:0] res,
                       input logic [1:0] cond, input logic f_ble, input logic f_eq);
    in_valid   = v;
    wb_sel     = sel;
    alu_result = res;
    br_cond    = cond;
    ble        = f_ble;
    branch_eq  = f_eq;
  endtask

  initial begin
    Reset_n = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 2'b00, 16'h0000, 2'b00, 1'b0, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_acc", acc, 16'h0000);
    check("rst_retire", retire_cnt, 16'h0000);
    check("rst_taken", {15'd0, branch_taken}, 16'd0);
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check_flags("rst_flags", 16'h0000);
    Reset_n = 1'b1;

    // Accumulator write, one-cycle latency, then retire.
    drive(1'b1, 2'b01, 16'h0005, 2'b00, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("wr5_acc", acc, 16'h0005);
    check("wr5_valid", {15'd0, out_valid}, 16'd1);
    out_ready = 1'b1;
    tick();
    check("wr5_retire", retire_cnt, 16'd1);
    check("wr5_idle", {15'd0, out_valid}, 16'd0);
    out_ready = 1'b0;

    // Branch evaluation across all four conditions; acc must not move.
    drive(1'b1, 2'b10, 16'h7777, 2'b00, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    check("beq_taken", {15'd0, branch_taken}, 16'd1);
    check("beq_acc", acc, 16'h0005);
    out_ready = 1'b1;
    drive(1'b1, 2'b10, 16'h1111, 2'b11, 1'b1, 1'b0);
    tick();
    check("bgt_taken", {15'd0, branch_taken}, 16'd0);
    check("bgt_valid", {15'd0, out_valid}, 16'd1);
    check("bgt_retire", retire_cnt, 16'd2);
    check("bgt_acc", acc, 16'h0005);
    drive(1'b1, 2'b10, 16'h2222, 2'b01, 1'b0, 1'b0);
    tick();
    check("bne_taken", {15'd0, branch_taken}, 16'd1);
    drive(1'b1, 2'b10, 16'h3333, 2'b10, 1'b0, 1'b1);
    tick();
    check("ble_taken", {15'd0, branch_taken}, 16'd0);
    drive(1'b1, 2'b01, 16'h4444, 2'b11, 1'b0, 1'b0);
    tick();
    check("acc_wr_not_branch", {15'd0, branch_taken}, 16'd0);
    check("acc_wr_4444", acc, 16'h4444);
    in_valid = 1'b0;
    tick();
    check("drain_retire", retire_cnt, 16'd6);
    check("drain_valid", {15'd0, out_valid}, 16'd0);
    check("drain_taken", {15'd0, branch_taken}, 16'd0);
    out_ready = 1'b0;

    // Backpressure: held entry stays put while in_valid is ignored.
    drive(1'b1, 2'b01, 16'h0004, 2'b00, 1'b0, 1'b0);
    tick();
    alu_result = 16'h0009;
    #1;
    check("bp_in_ready", {15'd0, in_ready}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_acc", acc, 16'h0004);
      check("bp_valid", {15'd0, out_valid}, 16'd1);
      check("bp_retire", retire_cnt, 16'd6);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", {15'd0, in_ready}, 16'd1);
    tick();
    in_valid = 1'b0;
    check("bp_acc9", acc, 16'h0009);
    check("bp_retire7", retire_cnt, 16'd7);
    tick();
    check("bp_drain", retire_cnt, 16'd8);

    // Back-to-back stream from a clean reset.
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 2'b01, 16'h0001, 2'b00, 1'b0, 1'b0);
    tick();
    check("b2b_acc1", acc, 16'h0001);
    alu_result = 16'h0002;
    tick();
    check("b2b_acc2", acc, 16'h0002);
    check("b2b_valid2", {15'd0, out_valid}, 16'd1);
    alu_result = 16'h0003;
    tick();
    check("b2b_acc3", acc, 16'h0003);
    check("b2b_valid3", {15'd0, out_valid}, 16'd1);
    in_valid = 1'b0;
    tick();
    check("b2b_retire", retire_cnt, 16'd3);

    // Flags follow the accumulator.
    drive(1'b1, 2'b01, 16'h8000, 2'b00, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check_flags("flags_8000", 16'h8000);
    drive(1'b1, 2'b01, 16'h0000, 2'b00, 1'b0, 1'b0);
    tick();
    check_flags("flags_0000", 16'h0000);
    in_valid = 1'b0;
    tick();

    // Wrap: after reset, 65536 streaming edges leave retire_cnt at FFFF.
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 2'b00, 16'h0000, 2'b00, 1'b0, 1'b0);
    repeat (65536) @(posedge CLK);
    #1;
    check("wrap_ffff", retire_cnt, 16'hFFFF);
    in_valid = 1'b0;
    tick();
    check("wrap_0000", retire_cnt, 16'h0000);
    check("wrap_idle", {15'd0, out_valid}, 16'd0);

    // Asynchronous reset mid-HOLD drops the entry without retiring it.
    out_ready = 1'b0;
    drive(1'b1, 2'b01, 16'h1234, 2'b00, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("hold_acc", acc, 16'h1234);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_valid", {15'd0, out_valid}, 16'd0);
    check("async_acc", acc, 16'h0000);
    check("async_retire", retire_cnt, 16'h0000);
    Reset_n = 1'b1;
    drive(1'b1, 2'b01, 16'h00AA, 2'b00, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    check("post_rst_acc", acc, 16'h00AA);
    check("post_rst_valid", {15'd0, out_valid}, 16'd1);
    check("post_rst_retire", retire_cnt, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
